// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and widths for the load/store unit.
// Revision: 1.0
`default_nettype none

package lsu_pkg;

   localparam int LSU_W = 32;

   typedef enum logic [1:0] {
      SZ_B   = 2'd0,
      SZ_H   = 2'd1,
      SZ_W   = 2'd2,
      SZ_RSV = 2'd3
   } size_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RMW_RD = 3'd2,
      WRITE  = 3'd3,
      RESP   = 3'd4
   } state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// lsu_align: little-endian extract (load) and merge (sub-word store) against the byte-reversed memory word.
// Revision: 1.0
`default_nettype none

module lsu_align
   import lsu_pkg::*;
(
   input  logic [LSU_W-1:0] i_mem_rd,
   input  logic [1:0]       i_size,
   input  logic             i_signed,
   input  logic [LSU_W-1:0] i_wdata,
   output logic [LSU_W-1:0] o_rdata,
   output logic [LSU_W-1:0] o_wd
);

   logic [LSU_W-1:0] w_rev;

   // mem_rd carries the byte at addr in its top lane; w_rev puts it in the bottom lane.
   assign w_rev = {i_mem_rd[7:0], i_mem_rd[15:8], i_mem_rd[23:16], i_mem_rd[31:24]};

   always_comb begin
      o_rdata = w_rev;
      o_wd    = i_wdata;
      case (i_size)
         SZ_B: begin
            o_rdata = {{24{i_signed & w_rev[7]}}, w_rev[7:0]};
            o_wd    = {w_rev[31:8], i_wdata[7:0]};
         end
         SZ_H: begin
            o_rdata = {{16{i_signed & w_rev[15]}}, w_rev[15:0]};
            o_wd    = {w_rev[31:16], i_wdata[15:0]};
         end
         default: begin
            o_rdata = w_rev;
            o_wd    = i_wdata;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// load_store_unit: valid/ready load/store initiator for data_mem with RMW sub-word stores and range checks.
// Optional macro MISALIGN_TRAP_EN rejects misaligned half/word accesses. Revision: 1.0
`default_nettype none

module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 256
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_signed,
   input  logic [LSU_W-1:0] req_addr,
   input  logic [LSU_W-1:0] req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [LSU_W-1:0] resp_rdata,
   output logic             resp_err,
   output logic [LSU_W-1:0] mem_addr,
   output logic [LSU_W-1:0] mem_wd,
   output logic             mem_we,
   input  logic [LSU_W-1:0] mem_rd
);

   localparam logic [LSU_W-1:0] C_MAX_ADDR = LSU_W'(MEM_BYTES - 4);

   state_e           r_state;
   state_e           w_next;
   logic [LSU_W-1:0] r_addr;
   size_e            r_size;
   logic             r_signed;
   logic [LSU_W-1:0] r_wd;
   logic [LSU_W-1:0] r_rdata;
   logic             r_err;

   logic             w_accept;
   logic             w_misalign;
   logic             w_bad;
   logic [LSU_W-1:0] w_ext;
   logic [LSU_W-1:0] w_merge;

   assign w_accept = req_valid & req_ready;

`ifdef MISALIGN_TRAP_EN
   assign w_misalign = ((req_size == SZ_H) & req_addr[0]) |
                       ((req_size == SZ_W) & (req_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   // data_mem always touches addr..addr+3, so every size is range-checked as a word.
   assign w_bad = (req_size == SZ_RSV) | (req_addr > C_MAX_ADDR) | w_misalign;

   lsu_align u_align (
      .i_mem_rd (mem_rd),
      .i_size   (r_size),
      .i_signed (r_signed),
      .i_wdata  (r_wd),
      .o_rdata  (w_ext),
      .o_wd     (w_merge)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_addr   = '0;
      mem_wd     = '0;
      mem_we     = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (w_accept) begin
               if (w_bad)                          w_next = RESP;
               else if (!req_we)                   w_next = LOAD;
               else if (req_size == SZ_W)          w_next = WRITE;
               else                                w_next = RMW_RD;
            end
         end
         LOAD: begin
            mem_addr = r_addr;
            w_next   = RESP;
         end
         RMW_RD: begin
            mem_addr = r_addr;
            w_next   = WRITE;
         end
         WRITE: begin
            mem_addr = r_addr;
            mem_wd   = r_wd;
            mem_we   = 1'b1;
            w_next   = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // r_wd holds the raw store data until RMW_RD replaces it with the merged word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_addr   <= '0;
         r_size   <= SZ_B;
         r_signed <= 1'b0;
         r_wd     <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr   <= req_addr;
                  r_size   <= size_e'(req_size);
                  r_signed <= req_signed;
                  r_wd     <= req_wdata;
                  r_rdata  <= '0;
                  r_err    <= w_bad;
               end
            end
            LOAD:   r_rdata <= w_ext;
            RMW_RD: r_wd    <= w_merge;
            RESP: begin
               if (resp_ready) begin
                  r_rdata <= '0;
                  r_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with a scoreboard queue and an independent response monitor.
// Revision: 1.0
`default_nettype none

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic        mem_we;
   logic [31:0] mem_rd;

   load_store_unit #(.MEM_BYTES(256)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_we     (mem_we),
      .mem_rd     (mem_rd)
   );

   always #5 clk = ~clk;

   // data_mem model: big-endian read lanes, little-endian write lanes.
   logic [7:0] mem [0:255];
   logic       mem_inited = 1'b0;
   wire  [7:0] ma = mem_addr[7:0];

   assign mem_rd = (mem_addr <= 32'd252) ?
                   {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]} : 32'h0;

   always @(posedge clk) begin
      if (!mem_inited) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
         mem_inited <= 1'b1;
      end else if (mem_we && mem_addr <= 32'd252) begin
         mem[ma]        <= mem_wd[7:0];
         mem[ma + 8'd1] <= mem_wd[15:8];
         mem[ma + 8'd2] <= mem_wd[23:16];
         mem[ma + 8'd3] <= mem_wd[31:24];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endfunction

   typedef struct {
      logic        err;
      logic [31:0] rd;
      int          lat;
      int          wes;
      string       name;
   } exp_t;

   exp_t q[$];
   int   accept_cyc = 0;
   int   n_pop = 0;
   int   we_cnt = 0;

   // Monitor: latency, stability while stalled, and per-response comparisons.
   int          we_base = 0;
   bit          seen = 1'b0;
   int          lat_obs = 0;
   logic [31:0] held_rd;
   logic        held_err;
   exp_t        e;

   always @(negedge clk) begin
      if (mem_we) we_cnt++;
      if (resp_valid) begin
         if (!seen) begin
            seen     = 1'b1;
            lat_obs  = cyc - accept_cyc + 1;
            held_rd  = resp_rdata;
            held_err = resp_err;
            chk("resp_mem_idle", {mem_we, mem_addr[15:0], mem_wd[14:0]}, 32'h0);
         end else if (!resp_ready) begin
            chk("stall_stable", {resp_rdata[30:0] ^ held_rd[30:0], resp_err ^ held_err}, 32'h0);
            chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
         end
         if (resp_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_resp", 32'h1, 32'h0);
            end else begin
               e = q.pop_front();
               chk({e.name, "_err"},   {31'h0, resp_err}, {31'h0, e.err});
               chk({e.name, "_rdata"}, resp_rdata, e.rd);
               chk({e.name, "_lat"},   32'(lat_obs), 32'(e.lat));
               chk({e.name, "_we"},    32'(we_cnt - we_base), 32'(e.wes));
            end
            we_base = we_cnt;
            seen    = 1'b0;
            n_pop++;
         end
      end
   end

   task automatic issue(input string name, input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic e_err,
                        input logic [31:0] e_rd, input int e_lat, input int e_we, input bit stall);
      int   t;
      int   target;
      exp_t x;
      t = 0;
      @(posedge clk); #1;
      while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (!req_ready) chk({name, "_req_ready_timeout"}, 32'h0, 32'h1);
      x.err = e_err; x.rd = e_rd; x.lat = e_lat; x.wes = e_we; x.name = name;
      q.push_back(x);
      target     = n_pop + 1;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      if (stall) resp_ready = 1'b0;
      @(posedge clk); #1;
      accept_cyc = cyc;
      req_valid  = 1'b0;
      if (stall) begin
         repeat (6) @(posedge clk);
         #1 resp_ready = 1'b1;
      end
      t = 0;
      while (n_pop < target && t < 60) begin @(posedge clk); #1; t++; end
      if (n_pop < target) begin
         chk({name, "_resp_timeout"}, 32'h0, 32'h1);
         q.delete();
      end
   endtask

   initial begin
      int we_snap;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_outputs", {resp_valid, resp_err, mem_we, 29'h0}, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wd", mem_wd, 32'h0);
      rst_n = 1'b1;

      issue("sw0",   1'b1, 2'd2, 1'b0, 32'd0,   32'h11223344, 1'b0, 32'h0, 2, 1, 1'b0);
      chk("sw0_bytes", {mem[0], mem[1], mem[2], mem[3]}, 32'h44332211);
      issue("lw0",   1'b0, 2'd2, 1'b0, 32'd0,   32'h0,        1'b0, 32'h11223344, 2, 0, 1'b0);
      issue("sb1",   1'b1, 2'd0, 1'b0, 32'd1,   32'hDEADBEAB, 1'b0, 32'h0, 3, 1, 1'b0);
      issue("lw0b",  1'b0, 2'd2, 1'b0, 32'd0,   32'h0,        1'b0, 32'h1122AB44, 2, 0, 1'b0);
      issue("lbs1",  1'b0, 2'd0, 1'b1, 32'd1,   32'h0,        1'b0, 32'hFFFFFFAB, 2, 0, 1'b0);
      issue("lbu1",  1'b0, 2'd0, 1'b0, 32'd1,   32'h0,        1'b0, 32'h000000AB, 2, 0, 1'b0);
      issue("lhs0",  1'b0, 2'd1, 1'b1, 32'd0,   32'h0,        1'b0, 32'hFFFFAB44, 2, 0, 1'b0);
      issue("lw253", 1'b0, 2'd2, 1'b0, 32'd253, 32'h0,        1'b1, 32'h0, 1, 0, 1'b0);
      issue("lw252", 1'b0, 2'd2, 1'b0, 32'd252, 32'h0,        1'b0, 32'hFFFEFDFC, 2, 0, 1'b0);
      issue("rsv",   1'b0, 2'd3, 1'b0, 32'd0,   32'h0,        1'b1, 32'h0, 1, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
      issue("lh1",   1'b0, 2'd1, 1'b0, 32'd1,   32'h0,        1'b1, 32'h0, 1, 0, 1'b0);
`else
      issue("lh1",   1'b0, 2'd1, 1'b0, 32'd1,   32'h0,        1'b0, 32'h000022AB, 2, 0, 1'b0);
`endif
      issue("sh2",   1'b1, 2'd1, 1'b0, 32'd2,   32'h1234BEEF, 1'b0, 32'h0, 3, 1, 1'b0);
      issue("lw0c",  1'b0, 2'd2, 1'b0, 32'd0,   32'h0,        1'b0, 32'hBEEFAB44, 2, 0, 1'b0);
      chk("sh2_upper_bytes", {16'h0, mem[5], mem[4]}, 32'h00000504);
      issue("sb255", 1'b1, 2'd0, 1'b0, 32'd255, 32'h0000005A, 1'b1, 32'h0, 1, 0, 1'b0);
      issue("sw253", 1'b1, 2'd2, 1'b0, 32'd253, 32'hCAFEF00D, 1'b1, 32'h0, 1, 0, 1'b0);
      chk("sw253_untouched", {8'h0, mem[253], mem[254], mem[255]}, 32'h00FDFEFF);
      issue("lw_stall", 1'b0, 2'd2, 1'b0, 32'd0, 32'h0,       1'b0, 32'hBEEFAB44, 2, 0, 1'b1);

      // Reset while the sub-word store sits in RMW_RD must abandon it without writing.
      @(posedge clk); #1;
      we_snap    = we_cnt;
      req_we     = 1'b1;
      req_size   = 2'd0;
      req_addr   = 32'd8;
      req_wdata  = 32'h00000077;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      rst_n      = 1'b0;
      @(posedge clk); #1;
      rst_n      = 1'b1;
      chk("rstmid_mem_we", {31'h0, mem_we}, 32'h0);
      chk("rstmid_req_ready", {31'h0, req_ready}, 32'h1);
      repeat (4) @(posedge clk);
      #1;
      chk("rstmid_no_write", {24'h0, mem[8]}, 32'h00000008);
      chk("rstmid_we_count", 32'(we_cnt - we_snap), 32'h0);
      chk("rstmid_resp_valid", {31'h0, resp_valid}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
